doorlock_dual_mode: RTL and testbench
=====================================

Name: doorlock_dual_mode

Overview:
- Keypad door-lock controller for the DE0 board with two modes: ACTIVE (normal unlock) and SET (enter a new password).
- Takes bouncy active-low '*' and '#' pushbuttons and a clean one-hot 10-key digit bus.
- Drives a timed `open` pulse on a correct code and a timed `alarm` pulse on a wrong one.

Parameters:
- MAX_DIGITS, 8: maximum password / entry length in digits.
- DB_CYCLES, 4: consecutive stable samples needed to accept a button press or release.
- HOLD_CYCLES, 4: clock cycles that `open` or `alarm` stays asserted.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- star  input  1  '*' button, active-low (0 = pushed), may bounce.
- sharp  input  1  '#' button, active-low, may bounce.
- number  input  10  digit keys, one-hot active-high; bit k = digit k.
- open  output  1  unlock pulse, HOLD_CYCLES long.
- alarm  output  1  wrong-code pulse, HOLD_CYCLES long.
- mode_active  output  1  high while in ACTIVE mode.
- mode_set  output  1  high while in SET mode.

Behaviour:
- Reset (asynchronous, active-high), all values below:
  - mode = ACTIVE (state value 0); SET = 1.
  - Stored password length = 0; entry buffer cleared; overflow flag cleared.
  - open = 0, alarm = 0, mode_active = 1, mode_set = 0.
- Button debounce, per star and sharp:
  - Input registered once.
  - Debounced level flips to "pressed" only after DB_CYCLES consecutive low samples.
  - Flips back to "released" only after DB_CYCLES consecutive high samples.
  - One-cycle `press` event on the released-to-pressed transition only.
  - Glitches shorter than DB_CYCLES are ignored; a bouncy push yields exactly one event.
- Digit capture:
  - `number` is registered; a digit event occurs when the previous sample was 0 and the current sample is exactly one-hot.
  - Digit value = index of the set bit (4 bits).
  - Samples that are multi-hot are ignored.
  - A key held for several cycles gives one event.
- Entry buffer:
  - Each digit event appends to the buffer and increments the count.
  - An event at count == MAX_DIGITS sets overflow; further digits are discarded.
- ACTIVE mode:
  - sharp press → go to SET mode; clear buffer, count and overflow.
  - star press → compare, then clear buffer/count/overflow.
    - Match requires count == stored length, stored length > 0, no overflow, and all digits equal.
    - Match → open = 1 for HOLD_CYCLES, starting the cycle after the press event.
    - Otherwise → alarm = 1 for HOLD_CYCLES.
- SET mode:
  - Digits accumulate into the buffer.
  - sharp press with count ≥ 1 and no overflow → buffer and count become the stored password; return to ACTIVE.
  - sharp press with count 0 or overflow → old password kept; return to ACTIVE.
  - star press is ignored; open and alarm stay 0.
- Simultaneous events:
  - star and sharp press events in the same cycle: sharp wins, star is dropped.
  - A digit event in the same cycle as a star/sharp event is dropped.
- New pulse while open/alarm is active: the counter restarts, and the other output is forced low.
- Outputs are registered; mode_active = (state == ACTIVE), mode_set = (state == SET).

Decomposition:
- Shared package holds:
  - the mode enum (ACTIVE = 0, SET = 1);
  - the digit width (4);
  - defaults for MAX_DIGITS, DB_CYCLES and HOLD_CYCLES.
- One sub-module, key_debounce (sync register, stable counter, press-event output), instantiated for star and sharp.
- Mode FSM, digit capture, buffers, compare and pulse timer live in the top.

Test Plan:
- Reset, then idle → open = 0, alarm = 0, mode_active = 1, mode_set = 0.
- Set "8,3" with bouncy '#' (pattern low 1/high 1/low 2/high 2/low 10/high 1/low 1/high 2/low 2):
  - exactly one press per push;
  - mode_set = 1 between the two '#', mode returns to 0 afterwards.
- Codes against stored "8,3", each completed with '*':
  - "8" → alarm pulse, exactly HOLD_CYCLES long;
  - "8,3" → open pulse, HOLD_CYCLES long, alarm stays 0;
  - "8,6" → alarm;
  - "8,3,3" → alarm.
- Set "7,2,5", then codes completed with '*':
  - "7,2,5" → open;
  - "7,3,5" → alarm;
  - "7,3,5,9,1" → alarm;
  - "7,2" → alarm.
- Set "0,4,9,6", then "0,4,9"+'*' → alarm.
  - Then set "9", then "9"+'*' → open, and "0,4,9"+'*' → alarm.
- Boundary cases:
  - '#','#' with no digits → old password kept.
  - 9 digits in SET then '#' → old password kept.
  - '*' straight after reset → alarm.
  - rst asserted mid-entry → immediate return to ACTIVE with outputs 0.

Source files
------------

// File: rtl/doorlock_dual_mode_pkg.sv
// Shared types, widths and default parameters for the dual-mode door lock.
package doorlock_dual_mode_pkg;

    // Controller mode: normal unlock operation or new-password entry
    typedef enum logic {
        MODE_ACTIVE = 1'b0,
        MODE_SET    = 1'b1
    } mode_e;

    localparam int DIGIT_W          = 4;
    localparam int NUM_KEYS         = 10;
    localparam int MAX_DIGITS_DEF   = 8;
    localparam int DB_CYCLES_DEF    = 4;
    localparam int HOLD_CYCLES_DEF  = 4;

    // True when exactly one key of the digit bus is set
    function automatic logic isOneHot(input logic [NUM_KEYS-1:0] keys);
        return (keys != '0) && ((keys & (keys - NUM_KEYS'(1))) == '0);
    endfunction

    // Index of the set key; only meaningful for a one-hot input
    function automatic logic [DIGIT_W-1:0] keyToDigit(input logic [NUM_KEYS-1:0] keys);
        logic [DIGIT_W-1:0] digit;
        digit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[k]) begin
                digit = DIGIT_W'(k);
            end
        end
        return digit;
    endfunction

endpackage

// File: rtl/doorlock_dual_mode_key_debounce.sv
// Debouncer for one active-low pushbutton, producing a single-cycle press event.
module key_debounce
    import doorlock_dual_mode_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] stableCnt_q, stableCnt_d;
    logic          press_q, press_d;

    // Register the raw button once; reset value is "released" (high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= btn_n_i;
        end
    end

    // Count consecutive samples disagreeing with the debounced level and flip after DB_CYCLES of them
    always_comb begin
        level_d     = level_q;
        stableCnt_d = '0;
        press_d     = 1'b0;
        if ((~sync_q) != level_q) begin
            if (stableCnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                stableCnt_d = stableCnt_q + CW'(1);
            end
        end
    end

    // Debounced level, run counter and registered press event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= 1'b0;
            stableCnt_q <= '0;
            press_q     <= 1'b0;
        end else begin
            level_q     <= level_d;
            stableCnt_q <= stableCnt_d;
            press_q     <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/doorlock_dual_mode.sv
// Keypad door lock with ACTIVE (unlock) and SET (new password) modes and timed open/alarm pulses.
module doorlock_dual_mode
    import doorlock_dual_mode_pkg::*;
#(
    parameter int MAX_DIGITS  = MAX_DIGITS_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                star,
    input  logic                sharp,
    input  logic [NUM_KEYS-1:0] number,
    output logic                open,
    output logic                alarm,
    output logic                mode_active,
    output logic                mode_set
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    mode_e                state_q, state_d;
    logic [NUM_KEYS-1:0]  numSync_q, numPrev_q;
    logic [DIGIT_W-1:0]   entry_q [MAX_DIGITS];
    logic [DIGIT_W-1:0]   entry_d [MAX_DIGITS];
    logic [DIGIT_W-1:0]   pass_q  [MAX_DIGITS];
    logic [DIGIT_W-1:0]   pass_d  [MAX_DIGITS];
    logic [CW-1:0]        entryCnt_q, entryCnt_d;
    logic [CW-1:0]        passLen_q, passLen_d;
    logic                 ovf_q, ovf_d;
    logic                 open_q, open_d;
    logic                 alarm_q, alarm_d;
    logic [HW-1:0]        hold_q, hold_d;

    logic                 starEvt, sharpEvt, digitEvt, keyEvt;
    logic                 digitsEqual, match;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_star (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (star),
        .press_o (starEvt)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_sharp (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (sharp),
        .press_o (sharpEvt)
    );

    // Two-stage capture of the digit bus so a fresh key is seen as a 0 -> one-hot step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            numSync_q <= '0;
            numPrev_q <= '0;
        end else begin
            numSync_q <= number;
            numPrev_q <= numSync_q;
        end
    end

    assign digitEvt = (numPrev_q == '0) && isOneHot(numSync_q);
    assign keyEvt   = starEvt || sharpEvt;

    // Compare the entry against the stored password
    always_comb begin
        digitsEqual = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < int'(passLen_q)) && (entry_q[i] != pass_q[i])) begin
                digitsEqual = 1'b0;
            end
        end
        match = digitsEqual && (entryCnt_q == passLen_q) && (passLen_q != '0) && !ovf_q;
    end

    // Mode FSM, entry buffer, password store and pulse timer next-state
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        entryCnt_d = entryCnt_q;
        ovf_d      = ovf_q;
        pass_d     = pass_q;
        passLen_d  = passLen_q;
        open_d     = open_q;
        alarm_d    = alarm_q;
        hold_d     = hold_q;

        if (open_q || alarm_q) begin
            if (hold_q == '0) begin
                open_d  = 1'b0;
                alarm_d = 1'b0;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end

        if (digitEvt && !keyEvt) begin
            if (entryCnt_q == CW'(MAX_DIGITS)) begin
                ovf_d = 1'b1;
            end else begin
                entry_d[entryCnt_q[IW-1:0]] = keyToDigit(numSync_q);
                entryCnt_d                  = entryCnt_q + CW'(1);
            end
        end

        case (state_q)
            MODE_ACTIVE: begin
                if (sharpEvt) begin
                    state_d    = MODE_SET;
                    entry_d    = '{default: '0};
                    entryCnt_d = '0;
                    ovf_d      = 1'b0;
                    open_d     = 1'b0;
                    alarm_d    = 1'b0;
                end else if (starEvt) begin
                    open_d     = match;
                    alarm_d    = !match;
                    hold_d     = HW'(HOLD_CYCLES - 1);
                    entry_d    = '{default: '0};
                    entryCnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            MODE_SET: begin
                if (sharpEvt) begin
                    if ((entryCnt_q != '0) && !ovf_q) begin
                        pass_d    = entry_q;
                        passLen_d = entryCnt_q;
                    end
                    state_d    = MODE_ACTIVE;
                    entry_d    = '{default: '0};
                    entryCnt_d = '0;
                    ovf_d      = 1'b0;
                end
                open_d  = 1'b0;
                alarm_d = 1'b0;
            end
            default: begin
                state_d = MODE_ACTIVE;
            end
        endcase
    end

    // State, buffers and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MODE_ACTIVE;
            entry_q    <= '{default: '0};
            entryCnt_q <= '0;
            ovf_q      <= 1'b0;
            pass_q     <= '{default: '0};
            passLen_q  <= '0;
            open_q     <= 1'b0;
            alarm_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            entryCnt_q <= entryCnt_d;
            ovf_q      <= ovf_d;
            pass_q     <= pass_d;
            passLen_q  <= passLen_d;
            open_q     <= open_d;
            alarm_q    <= alarm_d;
            hold_q     <= hold_d;
        end
    end

    assign open        = open_q;
    assign alarm       = alarm_q;
    assign mode_active = (state_q == MODE_ACTIVE);
    assign mode_set    = (state_q == MODE_SET);

endmodule

// File: tb/tb_doorlock_dual_mode.sv
// Directed self-checking bench for the dual-mode door lock.
module tb_doorlock_dual_mode;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       star;
    logic       sharp;
    logic [9:0] number;
    logic       open;
    logic       alarm;
    logic       mode_active;
    logic       mode_set;

    int checks;
    int failures;
    int openTotal;
    int alarmTotal;
    int seq[$];

    doorlock_dual_mode #(
        .MAX_DIGITS  (8),
        .DB_CYCLES   (4),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .star        (star),
        .sharp       (sharp),
        .number      (number),
        .open        (open),
        .alarm       (alarm),
        .mode_active (mode_active),
        .mode_set    (mode_set)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Running totals of cycles with open / alarm high, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            openTotal  <= 0;
            alarmTotal <= 0;
        end else begin
            if (open === 1'b1) openTotal <= openTotal + 1;
            if (alarm === 1'b1) alarmTotal <= alarmTotal + 1;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveBtn(input bit isStar, input logic lvl, input int n);
        if (isStar) star = lvl;
        else sharp = lvl;
        waitCycles(n);
    endtask

    task automatic pushBtn(input bit isStar);
        driveBtn(isStar, 1'b0, 6);
        driveBtn(isStar, 1'b1, 8);
    endtask

    task automatic pushBouncySharp();
        int runs[9] = '{1, 1, 2, 2, 10, 1, 1, 2, 2};
        for (int k = 0; k < 9; k++) begin
            driveBtn(1'b0, (k % 2 == 0) ? 1'b0 : 1'b1, runs[k]);
        end
        driveBtn(1'b0, 1'b1, 8);
    endtask

    task automatic pressDigit(input int d);
        number = 10'b1 << d;
        waitCycles(2);
        number = '0;
        waitCycles(2);
    endtask

    task automatic enterSeq();
        foreach (seq[k]) pressDigit(seq[k]);
    endtask

    task automatic setPassword();
        pushBtn(1'b0);
        enterSeq();
        pushBtn(1'b0);
    endtask

    task automatic runCode(output int oc, output int ac);
        int o0, a0;
        o0 = openTotal;
        a0 = alarmTotal;
        enterSeq();
        pushBtn(1'b1);
        waitCycles(10);
        oc = openTotal - o0;
        ac = alarmTotal - a0;
    endtask

    task automatic test_reset();
        rst = 1'b1; star = 1'b1; sharp = 1'b1; number = '0;
        waitCycles(3);
        @(negedge clk);
        checks += 4;
        if (open !== 1'b0) begin failures++; $display("[TB] FAIL reset_open: got %b expected 0", open); end
        if (alarm !== 1'b0) begin failures++; $display("[TB] FAIL reset_alarm: got %b expected 0", alarm); end
        if (mode_active !== 1'b1) begin failures++; $display("[TB] FAIL reset_mode_active: got %b expected 1", mode_active); end
        if (mode_set !== 1'b0) begin failures++; $display("[TB] FAIL reset_mode_set: got %b expected 0", mode_set); end
        @(posedge clk); #1;
        rst = 1'b0;
        waitCycles(6);
        @(negedge clk);
        checks += 3;
        if (open !== 1'b0) begin failures++; $display("[TB] FAIL idle_open: got %b expected 0", open); end
        if (alarm !== 1'b0) begin failures++; $display("[TB] FAIL idle_alarm: got %b expected 0", alarm); end
        if (mode_active !== 1'b1) begin failures++; $display("[TB] FAIL idle_mode_active: got %b expected 1", mode_active); end
        @(posedge clk); #1;
    endtask

    task automatic test_star_after_reset();
        int oc, ac;
        seq = {};
        runCode(oc, ac);
        checks += 2;
        if (ac !== HOLD) begin failures++; $display("[TB] FAIL star_reset_alarm_cycles: got %0d expected %0d", ac, HOLD); end
        if (oc !== 0) begin failures++; $display("[TB] FAIL star_reset_open_cycles: got %0d expected 0", oc); end
    endtask

    task automatic test_set_bouncy();
        pushBouncySharp();
        @(negedge clk);
        checks += 2;
        if (mode_set !== 1'b1) begin failures++; $display("[TB] FAIL bouncy_enter_set: got %b expected 1", mode_set); end
        if (mode_active !== 1'b0) begin failures++; $display("[TB] FAIL bouncy_enter_active: got %b expected 0", mode_active); end
        @(posedge clk); #1;
        seq = '{8, 3};
        enterSeq();
        pushBouncySharp();
        @(negedge clk);
        checks += 2;
        if (mode_set !== 1'b0) begin failures++; $display("[TB] FAIL bouncy_exit_set: got %b expected 0", mode_set); end
        if (mode_active !== 1'b1) begin failures++; $display("[TB] FAIL bouncy_exit_active: got %b expected 1", mode_active); end
        @(posedge clk); #1;
    endtask

    task automatic test_codes_83();
        int oc, ac;
        int expOpen[4] = '{0, HOLD, 0, 0};
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: seq = '{8};
                1: seq = '{8, 3};
                2: seq = '{8, 6};
                default: seq = '{8, 3, 3};
            endcase
            runCode(oc, ac);
            checks += 2;
            if (oc !== expOpen[k]) begin failures++; $display("[TB] FAIL code83_%0d_open: got %0d expected %0d", k, oc, expOpen[k]); end
            if (ac !== HOLD - expOpen[k]) begin failures++; $display("[TB] FAIL code83_%0d_alarm: got %0d expected %0d", k, ac, HOLD - expOpen[k]); end
        end
    endtask

    task automatic test_codes_725();
        int oc, ac;
        int expOpen[4] = '{HOLD, 0, 0, 0};
        seq = '{7, 2, 5};
        setPassword();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: seq = '{7, 2, 5};
                1: seq = '{7, 3, 5};
                2: seq = '{7, 3, 5, 9, 1};
                default: seq = '{7, 2};
            endcase
            runCode(oc, ac);
            checks += 2;
            if (oc !== expOpen[k]) begin failures++; $display("[TB] FAIL code725_%0d_open: got %0d expected %0d", k, oc, expOpen[k]); end
            if (ac !== HOLD - expOpen[k]) begin failures++; $display("[TB] FAIL code725_%0d_alarm: got %0d expected %0d", k, ac, HOLD - expOpen[k]); end
        end
    endtask

    task automatic test_codes_0496();
        int oc, ac;
        seq = '{0, 4, 9, 6};
        setPassword();
        seq = '{0, 4, 9};
        runCode(oc, ac);
        checks += 2;
        if (ac !== HOLD) begin failures++; $display("[TB] FAIL code049_alarm: got %0d expected %0d", ac, HOLD); end
        if (oc !== 0) begin failures++; $display("[TB] FAIL code049_open: got %0d expected 0", oc); end
        seq = '{9};
        setPassword();
        runCode(oc, ac);
        checks += 2;
        if (oc !== HOLD) begin failures++; $display("[TB] FAIL code9_open: got %0d expected %0d", oc, HOLD); end
        if (ac !== 0) begin failures++; $display("[TB] FAIL code9_alarm: got %0d expected 0", ac); end
        seq = '{0, 4, 9};
        runCode(oc, ac);
        checks += 1;
        if (ac !== HOLD) begin failures++; $display("[TB] FAIL code049_after9_alarm: got %0d expected %0d", ac, HOLD); end
    endtask

    task automatic test_empty_and_overflow_set();
        int oc, ac;
        seq = {};
        setPassword();
        @(negedge clk);
        checks += 1;
        if (mode_active !== 1'b1) begin failures++; $display("[TB] FAIL empty_set_mode: got %b expected 1", mode_active); end
        @(posedge clk); #1;
        seq = '{9};
        runCode(oc, ac);
        checks += 1;
        if (oc !== HOLD) begin failures++; $display("[TB] FAIL empty_set_keeps_open: got %0d expected %0d", oc, HOLD); end
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        setPassword();
        seq = '{9};
        runCode(oc, ac);
        checks += 2;
        if (oc !== HOLD) begin failures++; $display("[TB] FAIL overflow_set_keeps_open: got %0d expected %0d", oc, HOLD); end
        if (ac !== 0) begin failures++; $display("[TB] FAIL overflow_set_keeps_alarm: got %0d expected 0", ac); end
    endtask

    task automatic test_multihot();
        int oc, ac;
        number = 10'b10_0000_0010;
        waitCycles(2);
        number = '0;
        waitCycles(2);
        seq = '{9};
        runCode(oc, ac);
        checks += 1;
        if (oc !== HOLD) begin failures++; $display("[TB] FAIL multihot_ignored_open: got %0d expected %0d", oc, HOLD); end
    endtask

    task automatic test_back_to_back();
        int o0, a0;
        o0 = openTotal;
        a0 = alarmTotal;
        star = 1'b0; sharp = 1'b0;
        waitCycles(6);
        star = 1'b1; sharp = 1'b1;
        waitCycles(10);
        @(negedge clk);
        checks += 3;
        if (mode_set !== 1'b1) begin failures++; $display("[TB] FAIL both_sharp_wins: got %b expected 1", mode_set); end
        if (alarmTotal - a0 !== 0) begin failures++; $display("[TB] FAIL both_star_dropped_alarm: got %0d expected 0", alarmTotal - a0); end
        if (openTotal - o0 !== 0) begin failures++; $display("[TB] FAIL both_star_dropped_open: got %0d expected 0", openTotal - o0); end
        @(posedge clk); #1;
        pushBtn(1'b0);
        @(negedge clk);
        checks += 1;
        if (mode_active !== 1'b1) begin failures++; $display("[TB] FAIL both_return_active: got %b expected 1", mode_active); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_entry();
        int oc, ac;
        pushBtn(1'b0);
        pressDigit(5);
        @(negedge clk);
        checks += 1;
        if (mode_set !== 1'b1) begin failures++; $display("[TB] FAIL mid_entry_in_set: got %b expected 1", mode_set); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks += 4;
        if (mode_set !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_mode_set: got %b expected 0", mode_set); end
        if (mode_active !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_mode_active: got %b expected 1", mode_active); end
        if (open !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_open: got %b expected 0", open); end
        if (alarm !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_alarm: got %b expected 0", alarm); end
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        seq = '{9};
        runCode(oc, ac);
        checks += 2;
        if (ac !== HOLD) begin failures++; $display("[TB] FAIL post_reset_code_alarm: got %0d expected %0d", ac, HOLD); end
        if (oc !== 0) begin failures++; $display("[TB] FAIL post_reset_code_open: got %0d expected 0", oc); end
    endtask

    // Run every scenario in order and report
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_star_after_reset();
        test_set_bouncy();
        test_codes_83();
        test_codes_725();
        test_codes_0496();
        test_empty_and_overflow_set();
        test_multihot();
        test_back_to_back();
        test_reset_mid_entry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
